// File: rtl/setting_entry.sv
// Front-panel parameter entry: debounced keys, BCD digit editing with a blinking cursor,
// target validation on start, and the start/reject/lock handshake to the bottling controller.
module setting_entry #(
  parameter int unsigned DEB_CYCLES    = 20,
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_RATE   = 200,
  parameter int unsigned REJECT_CYCLES = 1000
) (
  input  logic       clk_1khz,
  input  logic       switch_clr,
  input  logic       btn_1,
  input  logic       btn_2,
  input  logic       btn_3,
  input  logic       edit_en,
  output logic [3:0] target_pills3,
  output logic [3:0] target_pills2,
  output logic [3:0] target_pills1,
  output logic [3:0] target_bottles2,
  output logic [3:0] target_bottles1,
  output logic [2:0] cursor,
  output logic [4:0] flicker_mask,
  output logic       start_pulse,
  output logic       reject,
  output logic       locked
);

  localparam int unsigned DW      = $clog2(DEB_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW      = $clog2(RPT_MAX + 1);
  localparam int unsigned JW      = $clog2(REJECT_CYCLES + 1);

  typedef enum logic [1:0] {ST_EDIT, ST_REJECT, ST_LOCKED} state_t;

  logic [2:0] raw_c;
  logic [2:0] deb_lvl_c;
  logic [2:0] rise_c;
  logic [2:0] press;

  assign raw_c = {btn_3, btn_2, btn_1};

  // Per-key synchronizer, stability counter and registered press pulse.
  for (genvar i = 0; i < 3; i++) begin : g_key
    logic          sync1, sync2, deb, deb_d, press_q;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk_1khz or posedge switch_clr) begin
      if (switch_clr) begin
        sync1   <= 1'b0;
        sync2   <= 1'b0;
        deb     <= 1'b0;
        deb_d   <= 1'b0;
        press_q <= 1'b0;
        cnt     <= '0;
      end else begin
        sync1   <= raw_c[i];
        sync2   <= sync1;
        deb_d   <= deb;
        press_q <= deb & ~deb_d;
        if (sync2 == deb) begin
          cnt <= '0;
        end else if (cnt == DW'(DEB_CYCLES - 1)) begin
          deb <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end
    end

    assign deb_lvl_c[i] = deb;
    assign rise_c[i]    = deb & ~deb_d;
    assign press[i]     = press_q;
  end

  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_lim_c;
  logic          rep_active;
  logic          rep_ev;

  assign rep_lim_c = rep_active ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);

  // Auto-repeat on the increment key; timed from the press pulse, killed by release.
  always_ff @(posedge clk_1khz or posedge switch_clr) begin
    if (switch_clr) begin
      rep_cnt    <= '0;
      rep_active <= 1'b0;
      rep_ev     <= 1'b0;
    end else begin
      rep_ev <= 1'b0;
      if (!deb_lvl_c[0] || rise_c[0]) begin
        rep_cnt    <= '0;
        rep_active <= 1'b0;
      end else if (rep_cnt == rep_lim_c) begin
        rep_ev     <= 1'b1;
        rep_cnt    <= '0;
        rep_active <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + RW'(1);
      end
    end
  end

  logic inc_ev_c, start_ev_c, adv_ev_c;
  logic pills_nz_c, bottles_nz_c;
  logic [2:0] cursor_nxt_c;

  assign inc_ev_c     = press[0] | rep_ev;
  assign start_ev_c   = press[1];
  assign adv_ev_c     = press[2];
  assign pills_nz_c   = |{target_pills3, target_pills2, target_pills1};
  assign bottles_nz_c = |{target_bottles2, target_bottles1};
  assign cursor_nxt_c = (cursor >= 3'd4) ? 3'd0 : cursor + 3'd1;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [4:0] onehot5(input logic [2:0] c);
    return 5'b00001 << c;
  endfunction

  state_t        state;
  logic [JW-1:0] rej_cnt;
  logic          edit_en_d;

  // Entry FSM; start takes priority, increment lands on the pre-advance cursor digit.
  always_ff @(posedge clk_1khz or posedge switch_clr) begin
    if (switch_clr) begin
      state           <= ST_EDIT;
      rej_cnt         <= '0;
      edit_en_d       <= 1'b0;
      target_pills3   <= 4'd0;
      target_pills2   <= 4'd1;
      target_pills1   <= 4'd0;
      target_bottles2 <= 4'd0;
      target_bottles1 <= 4'd5;
      cursor          <= 3'd0;
      flicker_mask    <= 5'b00001;
      start_pulse     <= 1'b0;
      reject          <= 1'b0;
      locked          <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      edit_en_d   <= edit_en;
      case (state)
        ST_EDIT: begin
          if (edit_en) begin
            if (start_ev_c) begin
              if (pills_nz_c && bottles_nz_c) begin
                state        <= ST_LOCKED;
                start_pulse  <= 1'b1;
                locked       <= 1'b1;
                flicker_mask <= 5'b00000;
              end else begin
                state        <= ST_REJECT;
                reject       <= 1'b1;
                rej_cnt      <= '0;
                flicker_mask <= 5'b11111;
              end
            end else begin
              if (inc_ev_c) begin
                case (cursor)
                  3'd0:    target_pills3   <= bcd_inc(target_pills3);
                  3'd1:    target_pills2   <= bcd_inc(target_pills2);
                  3'd2:    target_pills1   <= bcd_inc(target_pills1);
                  3'd3:    target_bottles2 <= bcd_inc(target_bottles2);
                  3'd4:    target_bottles1 <= bcd_inc(target_bottles1);
                  default: ;
                endcase
              end
              if (adv_ev_c) begin
                cursor       <= cursor_nxt_c;
                flicker_mask <= onehot5(cursor_nxt_c);
              end
            end
          end
        end
        ST_REJECT: begin
          if (rej_cnt == JW'(REJECT_CYCLES - 1)) begin
            state        <= ST_EDIT;
            reject       <= 1'b0;
            flicker_mask <= onehot5(cursor);
          end else begin
            rej_cnt <= rej_cnt + JW'(1);
          end
        end
        ST_LOCKED: begin
          if (edit_en && !edit_en_d) begin
            state        <= ST_EDIT;
            locked       <= 1'b0;
            cursor       <= 3'd0;
            flicker_mask <= 5'b00001;
          end
        end
        default: state <= ST_EDIT;
      endcase
    end
  end

endmodule

// File: tb/tb_setting_entry.sv
// Directed bench for setting_entry: debounce, wrap, repeat, reject, lock and reset scenarios.
module tb_setting_entry;

  logic       clk_1khz = 1'b0;
  logic       switch_clr;
  logic       btn_1, btn_2, btn_3, edit_en;
  logic [3:0] target_pills3, target_pills2, target_pills1, target_bottles2, target_bottles1;
  logic [2:0] cursor;
  logic [4:0] flicker_mask;
  logic       start_pulse, reject, locked;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int sp_cnt   = 0;

  setting_entry dut (
    .clk_1khz        (clk_1khz),
    .switch_clr      (switch_clr),
    .btn_1           (btn_1),
    .btn_2           (btn_2),
    .btn_3           (btn_3),
    .edit_en         (edit_en),
    .target_pills3   (target_pills3),
    .target_pills2   (target_pills2),
    .target_pills1   (target_pills1),
    .target_bottles2 (target_bottles2),
    .target_bottles1 (target_bottles1),
    .cursor          (cursor),
    .flicker_mask    (flicker_mask),
    .start_pulse     (start_pulse),
    .reject          (reject),
    .locked          (locked)
  );

  always #5 clk_1khz = ~clk_1khz;

  always @(negedge clk_1khz) if (start_pulse) sp_cnt++;

  function automatic logic [19:0] digits();
    return {target_pills3, target_pills2, target_pills1, target_bottles2, target_bottles1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, return positioned on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_1khz);
    @(negedge clk_1khz);
  endtask

  task automatic set_key(input int idx, input logic v);
    case (idx)
      0: btn_1 = v;
      1: btn_2 = v;
      default: btn_3 = v;
    endcase
  endtask

  task automatic press_key(input int idx);
    set_key(idx, 1'b1);
    cyc(30);
    set_key(idx, 1'b0);
    cyc(30);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_digits"}, 32'(digits()), 32'h01005);
    check({tag, "_cursor"}, 32'(cursor), 32'd0);
    check({tag, "_flicker"}, 32'(flicker_mask), 32'h01);
    check({tag, "_flags"}, 32'({start_pulse, reject, locked}), 32'd0);
  endtask

  initial begin
    switch_clr = 1'b1;
    btn_1 = 1'b0; btn_2 = 1'b0; btn_3 = 1'b0;
    edit_en = 1'b1;
    cyc(3);
    check_reset("rst");
    switch_clr = 1'b0;
    cyc(2);

    // Cursor to pills1
    press_key(2);
    press_key(2);
    check("adv2_cursor", 32'(cursor), 32'd2);
    check("adv2_flicker", 32'(flicker_mask), 32'h04);

    // Bouncy press, then steady high: exactly one increment at k+23
    for (int i = 0; i < 4; i++) begin
      btn_1 = 1'b1; cyc(5);
      btn_1 = 1'b0; cyc(3);
    end
    btn_1 = 1'b1;
    cyc(23);
    check("deb_early", 32'(target_pills1), 32'd0);
    cyc(1);
    check("deb_edge", 32'(target_pills1), 32'd1);
    cyc(6);
    btn_1 = 1'b0;
    cyc(30);
    check("deb_once", 32'(digits()), 32'h01105);

    // Nine more increments wrap pills1 with no carry
    for (int i = 0; i < 9; i++) press_key(0);
    check("wrap", 32'(digits()), 32'h01005);

    // Simultaneous increment+advance at cursor 4
    press_key(2);
    press_key(2);
    check("cur4", 32'(cursor), 32'd4);
    check("cur4_flicker", 32'(flicker_mask), 32'h10);
    btn_1 = 1'b1; btn_3 = 1'b1;
    cyc(30);
    btn_1 = 1'b0; btn_3 = 1'b0;
    cyc(30);
    check("simul_digits", 32'(digits()), 32'h01006);
    check("simul_cursor", 32'(cursor), 32'd0);
    check("simul_flicker", 32'(flicker_mask), 32'h01);

    // Auto-repeat: press, +500, +700, +900, +1100
    btn_1 = 1'b1;
    cyc(24);
    check("rpt_press", 32'(target_pills3), 32'd1);
    cyc(499);
    check("rpt_before", 32'(target_pills3), 32'd1);
    cyc(1);
    check("rpt_first", 32'(target_pills3), 32'd2);
    cyc(677);
    btn_1 = 1'b0;
    cyc(40);
    check("rpt_total", 32'(digits()), 32'h51006);

    // Bottles to 00, then start must reject
    for (int i = 0; i < 4; i++) press_key(2);
    for (int i = 0; i < 4; i++) press_key(0);
    check("bot00", 32'(digits()), 32'h51000);
    btn_2 = 1'b1;
    cyc(23);
    check("rej_early", 32'(reject), 32'd0);
    cyc(1);
    check("rej_on", 32'(reject), 32'd1);
    check("rej_flicker", 32'(flicker_mask), 32'h1f);
    check("rej_locked", 32'(locked), 32'd0);
    cyc(7);
    btn_2 = 1'b0;
    cyc(992);
    check("rej_last", 32'(reject), 32'd1);
    cyc(1);
    check("rej_off", 32'(reject), 32'd0);
    check("rej_back_flicker", 32'(flicker_mask), 32'h10);
    check("rej_digits", 32'(digits()), 32'h51000);
    check("rej_no_start", 32'(sp_cnt), 32'd0);

    // Start with default targets
    switch_clr = 1'b1;
    cyc(2);
    check_reset("rst2");
    switch_clr = 1'b0;
    cyc(1);
    press_key(2);
    btn_2 = 1'b1;
    cyc(23);
    check("sp_early", 32'(start_pulse), 32'd0);
    cyc(1);
    check("sp_on", 32'({start_pulse, locked}), 32'h3);
    check("lock_flicker", 32'(flicker_mask), 32'h00);
    cyc(1);
    check("sp_off", 32'({start_pulse, locked}), 32'h1);
    cyc(28);
    btn_2 = 1'b0;
    cyc(30);
    edit_en = 1'b0;
    press_key(0);
    press_key(2);
    press_key(1);
    check("lock_digits", 32'(digits()), 32'h01005);
    check("lock_cursor", 32'(cursor), 32'd1);
    check("lock_held", 32'(locked), 32'd1);
    edit_en = 1'b1;
    cyc(1);
    check("unlock", 32'(locked), 32'd0);
    check("unlock_cursor", 32'(cursor), 32'd0);
    check("unlock_flicker", 32'(flicker_mask), 32'h01);
    check("sp_count", 32'(sp_cnt), 32'd1);
    edit_en = 1'b0;
    press_key(0);
    check("edit_dis", 32'(digits()), 32'h01005);
    edit_en = 1'b1;
    cyc(2);

    // Reset during REJECT
    for (int i = 0; i < 4; i++) press_key(2);
    for (int i = 0; i < 5; i++) press_key(0);
    check("bot00_b", 32'(digits()), 32'h01000);
    btn_2 = 1'b1;
    for (int i = 0; i < 60 && !reject; i++) cyc(1);
    check("rej_seen", 32'(reject), 32'd1);
    btn_2 = 1'b0;
    cyc(5);
    switch_clr = 1'b1;
    #1;
    check_reset("rst_rej");
    cyc(2);
    switch_clr = 1'b0;

    // Reset during held repeat; held key re-debounces to one press
    btn_1 = 1'b1;
    cyc(600);
    check("hold_pre", 32'(digits()), 32'h21005);
    switch_clr = 1'b1;
    #1;
    check("rst_rpt", 32'(digits()), 32'h01005);
    cyc(3);
    switch_clr = 1'b0;
    cyc(23);
    check("redeb_early", 32'(digits()), 32'h01005);
    cyc(1);
    check("redeb_edge", 32'(digits()), 32'h11005);
    cyc(300);
    btn_1 = 1'b0;
    cyc(30);
    check("redeb_once", 32'(digits()), 32'h11005);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/setting_entry.md
# setting_entry

Operator parameter-entry stage that sits directly upstream of the bottling controller. It debounces the three front-panel keys on `clk_1khz` and lets the operator edit the per-bottle pill target (3 BCD digits) and the bottle target (2 BCD digits) with a blinking cursor. It validates the setting on the start key, then hands the controller a one-cycle `start_pulse` together with stable BCD targets. It also drives the flicker mask for the five digit displays.

## Interface
Parameters:
- `DEB_CYCLES`, 20, consecutive stable samples required before the debounced level changes (20 ms at 1 kHz).
- `REPEAT_DELAY`, 500, hold time on `btn_1` before auto-repeat begins, in cycles.
- `REPEAT_RATE`, 200, auto-repeat period once repeat is active, in cycles.
- `REJECT_CYCLES`, 1000, duration of the REJECT state, in cycles.

Ports:
- `clk_1khz` in 1: sole clock, 1 kHz.
- `switch_clr` in 1: reset, asynchronous, active-high.
- `btn_1` in 1: increment key, active-high, raw and asynchronous.
- `btn_2` in 1: start/confirm key (QD), active-high, raw.
- `btn_3` in 1: cursor-advance key, active-high, raw. The top level supplies it already inverted.
- `edit_en` in 1: high while the controller is in SETTING.
- `target_pills3/2/1` out 4 each: pill target as BCD hundreds/tens/ones.
- `target_bottles2/1` out 4 each: bottle target as BCD tens/ones.
- `cursor` out 3: digit under edit, 0..4.
- `flicker_mask` out 5: bit i blinks digit i.
- `start_pulse` out 1: one-cycle strobe to the controller.
- `reject` out 1: high during REJECT. Used as the beeper request.
- `locked` out 1: high in LOCKED.

## Operation
- **Digit order for `cursor` 0..4:** pills3, pills2, pills1, bottles2, bottles1.
- **Key front end (one per key):**
  - 2-FF synchronizer, then a stability counter.
  - The debounced level changes only after the synchronized value differs from it for `DEB_CYCLES` consecutive cycles.
  - The counter clears on any sample equal to the current debounced level.
  - A press event is a one-cycle pulse on the debounced rising edge. Releases produce no event.
- **Auto-repeat on `btn_1` only:**
  - While the debounced level stays high, an extra increment event fires `REPEAT_DELAY` cycles after the press event.
  - Further events follow every `REPEAT_RATE` cycles.
  - Release stops repeat immediately.
- **FSM states:** EDIT, REJECT, LOCKED.
- **EDIT:**
  - Events are acted on only while `edit_en`=1. Otherwise they are discarded.
  - Increment: the selected digit goes +1, wrapping 9→0 with no carry into neighbouring digits.
  - Advance: `cursor`+1, wrapping 4→0.
  - Start, when the pill target ≠ 000 and the bottle target ≠ 00: assert `start_pulse` and go to LOCKED.
  - Start, otherwise: go to REJECT.
- **REJECT:**
  - Lasts `REJECT_CYCLES` cycles, then returns to EDIT.
  - All key events are discarded. Digits and cursor are held.
- **LOCKED:**
  - Digits are frozen and all key events are discarded.
  - Returns to EDIT on a rising edge of `edit_en` (compared against its registered previous value).
  - `cursor` resets to 0 on that return.
- **flicker_mask:**
  - EDIT: one-hot at `cursor`.
  - REJECT: 5'b11111.
  - LOCKED: 5'b00000.
- **Simultaneous events in the same cycle:**
  - Start wins; increment and advance are dropped.
  - Increment plus advance: the increment applies to the old cursor digit, then the cursor advances.
- **Width rules:** digits never leave 0..9; `cursor` never leaves 0..4.

## Timing
- **Reset values:**
  - State EDIT.
  - Pills 0,1,0 (pill target 010); bottles 0,5 (bottle target 05).
  - `cursor`=0, `flicker_mask`=5'b00001.
  - `start_pulse`=0, `reject`=0, `locked`=0.
  - All debounce and repeat counters cleared.
- **Key latency:** a raw key first sampled high at edge k, held steady, produces its press event in cycle k+2+`DEB_CYCLES`. The resulting digit, cursor or state update is visible on outputs one cycle later.
- **`start_pulse`:** high for exactly one cycle, in the same cycle that `locked` first reads 1. Targets are stable from that cycle on.
- **REJECT:** `reject` is high for exactly `REJECT_CYCLES` cycles.
- **Reset mid-operation:** an asynchronous `switch_clr` forces reset values immediately from any state. Any in-flight debounce or repeat is lost; a key still held after reset must be re-debounced and produces one press event.
- **Glitch rejection:** a glitch shorter than `DEB_CYCLES` cycles produces no event.

## Test plan
- **Debounce:** `btn_1` bounces 5 cycles high / 3 low ×4, then steady high 30 cycles → exactly one increment. pills1 0→1 at cycle 2+20+1 after the first steady-high sample.
- **Wrap, advance, simultaneous:** from reset, advance ×2, increment ×10 → pills1 ends at 0 with no carry (pills2 stays 1). Increment+advance in the same cycle at cursor 4 → bottles1 5→6, cursor 0.
- **Auto-repeat:** hold `btn_1` 1200 cycles at cursor 0 → increments at press, +500, +700, +900, +1100 = 5 in total. pills3 0→5.
- **Reject path:** set bottles to 00, press `btn_2` → `reject`=1 for 1000 cycles, `flicker_mask`=11111, no `start_pulse`, back to EDIT with digits unchanged.
- **Start/lock:** default targets, press `btn_2` → one-cycle `start_pulse`, `locked`=1, outputs 0,1,0 / 0,5. With `edit_en` low, `btn_1`/`btn_3` → no change. An `edit_en` 0→1 returns to EDIT with `cursor`=0.
- **Reset mid-operation:** assert `switch_clr` during REJECT and during a held `btn_1` repeat → all reset values immediately. After release, the held key yields one fresh press event.
